// File: rtl/kb_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: prefix FSM, Shift/Ctrl tracking, ASCII map, event FIFO.
// Optional auto-repeat suppression when KB_TYPEMATIC_FILTER_EN is defined.
module kb_scancode_decoder #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_frame_data,
  input  logic       i_frame_valid,
  input  logic       i_frame_err,
  input  logic       i_key_ready,
  output logic       o_key_valid,
  output logic [7:0] o_key_code,
  output logic       o_key_ext,
  output logic       o_key_break,
  output logic [7:0] o_ascii,
  output logic       o_shift,
  output logic       o_ctrl,
  output logic       o_overflow
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0] LetterCodes [26] = '{
    8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A,
    8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DigitCodes [10] = '{
    8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

  typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StPause} state_e;

  state_e      state_q, state_d;
  logic [2:0]  pause_cnt_q, pause_cnt_d;
  logic        emit;
  logic [7:0]  ev_code;
  logic        ev_ext, ev_brk;
  logic [7:0]  ascii;
  logic        suppress;

  logic        lshift_q, lshift_d, rshift_q, rshift_d;
  logic        lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic        overflow_q, overflow_d;

  logic [17:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic        push_req, push, pop, full;

  always_comb begin
    state_d     = state_q;
    pause_cnt_d = pause_cnt_q;
    emit        = 1'b0;
    ev_code     = i_frame_data;
    ev_ext      = 1'b0;
    ev_brk      = 1'b0;
    if (i_frame_valid) begin
      if (i_frame_err) begin
        state_d     = StIdle;
        pause_cnt_d = 3'd0;
      end else begin
        unique case (state_q)
          StIdle: begin
            case (i_frame_data)
              8'hE0: state_d = StExt;
              8'hF0: state_d = StBrk;
              8'hE1: begin
                state_d     = StPause;
                pause_cnt_d = 3'd7;
              end
              8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: begin
              end
              default: emit = 1'b1;
            endcase
          end
          StExt: begin
            if (i_frame_data == 8'hF0) begin
              state_d = StExtBrk;
            end else begin
              emit    = 1'b1;
              ev_ext  = 1'b1;
              state_d = StIdle;
            end
          end
          StBrk: begin
            emit    = 1'b1;
            ev_brk  = 1'b1;
            state_d = StIdle;
          end
          StExtBrk: begin
            emit    = 1'b1;
            ev_ext  = 1'b1;
            ev_brk  = 1'b1;
            state_d = StIdle;
          end
          StPause: begin
            pause_cnt_d = pause_cnt_q - 3'd1;
            if (pause_cnt_q == 3'd1) begin
              emit    = 1'b1;
              ev_code = 8'hE1;
              state_d = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // ASCII uses the modifier state from before this event's own update.
  always_comb begin
    ascii = 8'h00;
    if (!ev_ext && !ev_brk) begin
      for (int i = 0; i < 26; i++) begin
        if (ev_code == LetterCodes[i]) begin
          if (o_ctrl)       ascii = 8'(i + 1);
          else if (o_shift) ascii = 8'(8'h41 + i);
          else              ascii = 8'(8'h61 + i);
        end
      end
      for (int i = 0; i < 10; i++) begin
        if (ev_code == DigitCodes[i]) ascii = 8'(8'h30 + i);
      end
      case (ev_code)
        8'h29:   ascii = 8'h20;
        8'h5A:   ascii = 8'h0D;
        8'h66:   ascii = 8'h08;
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    lctrl_d  = lctrl_q;
    rctrl_d  = rctrl_q;
    if (emit) begin
      if (!ev_ext && ev_code == 8'h12) lshift_d = !ev_brk;
      if (!ev_ext && ev_code == 8'h59) rshift_d = !ev_brk;
      if (ev_code == 8'h14) begin
        if (ev_ext) rctrl_d = !ev_brk;
        else        lctrl_d = !ev_brk;
      end
    end
  end

`ifdef KB_TYPEMATIC_FILTER_EN
  logic [8:0] last_q, last_d;
  logic       last_vld_q, last_vld_d;

  always_comb begin
    last_d     = last_q;
    last_vld_d = last_vld_q;
    suppress   = 1'b0;
    if (emit) begin
      if (!ev_brk) begin
        if (last_vld_q && last_q == {ev_code, ev_ext}) begin
          suppress = 1'b1;
        end else begin
          last_d     = {ev_code, ev_ext};
          last_vld_d = 1'b1;
        end
      end else if (last_vld_q && last_q == {ev_code, ev_ext}) begin
        last_vld_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      last_q     <= 9'd0;
      last_vld_q <= 1'b0;
    end else begin
      last_q     <= last_d;
      last_vld_q <= last_vld_d;
    end
  end
`else
  assign suppress = 1'b0;
`endif

  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign pop      = o_key_valid && i_key_ready;
  assign push_req = emit && !suppress;
  assign push     = push_req && (!full || pop);

  always_comb begin
    overflow_d = overflow_q;
    if (push_req && full && !pop) overflow_d = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      pause_cnt_q <= 3'd0;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      overflow_q  <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pause_cnt_q <= pause_cnt_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      overflow_q  <= overflow_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

  // Storage needs no reset: the head is masked whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= {ev_code, ev_ext, ev_brk, ascii};
  end

  assign o_key_valid = (count_q != '0);
  assign o_key_code  = o_key_valid ? mem_q[rd_ptr_q][17:10] : 8'h00;
  assign o_key_ext   = o_key_valid ? mem_q[rd_ptr_q][9]     : 1'b0;
  assign o_key_break = o_key_valid ? mem_q[rd_ptr_q][8]     : 1'b0;
  assign o_ascii     = o_key_valid ? mem_q[rd_ptr_q][7:0]   : 8'h00;
  assign o_shift     = lshift_q | rshift_q;
  assign o_ctrl      = lctrl_q | rctrl_q;
  assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_kb_scancode_decoder.sv
// Directed plus randomized bench for kb_scancode_decoder against a byte-sequence reference model.
module tb_kb_scancode_decoder;
  localparam int Depth = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] frame_data = 8'h00;
  logic       frame_valid = 1'b0;
  logic       frame_err = 1'b0;
  logic       key_ready = 1'b0;
  logic       key_valid, key_ext, key_break, shift, ctrl, overflow;
  logic [7:0] key_code, ascii;

  always #5 clk = ~clk;

  kb_scancode_decoder #(.FIFO_DEPTH(Depth)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_frame_data (frame_data),
    .i_frame_valid(frame_valid),
    .i_frame_err  (frame_err),
    .i_key_ready  (key_ready),
    .o_key_valid  (key_valid),
    .o_key_code   (key_code),
    .o_key_ext    (key_ext),
    .o_key_break  (key_break),
    .o_ascii      (ascii),
    .o_shift      (shift),
    .o_ctrl       (ctrl),
    .o_overflow   (overflow)
  );

  typedef struct {
    logic [7:0] code;
    bit         ext;
    bit         brk;
    logic [7:0] asc;
  } ev_t;

  byte unsigned letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
    8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A,
    8'h1D, 8'h22, 8'h35, 8'h1A};
  byte unsigned digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E,
    8'h46};

  int n_cmp = 0;
  int n_bad = 0;
  int pops  = 0;

  ev_t          exp_q[$];
  byte unsigned seq[$];
  int           pause_left;
  bit           lsh, rsh, lct, rct, ovf_m;
  bit           tm_vld;
  logic [8:0]   tm_key;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    exp_q.delete();
    seq.delete();
    pause_left = 0;
    {lsh, rsh, lct, rct, ovf_m, tm_vld} = '0;
    tm_key = '0;
  endfunction

  function automatic logic [7:0] ref_ascii(input byte unsigned code);
    int r = 0;
    for (int i = 0; i < 26; i++)
      if (code == letters[i]) r = (lct || rct) ? i + 1 : (lsh || rsh) ? 65 + i : 97 + i;
    for (int i = 0; i < 10; i++)
      if (code == digits[i]) r = 48 + i;
    if (code == 8'h29) r = 32;
    if (code == 8'h5A) r = 13;
    if (code == 8'h66) r = 8;
    return 8'(r);
  endfunction

  function automatic void model_event(input byte unsigned code, input bit ext, input bit brk);
    ev_t e;
    bit  sup = 0;
    e.code = code;
    e.ext  = ext;
    e.brk  = brk;
    e.asc  = (!ext && !brk) ? ref_ascii(code) : 8'h00;
`ifdef KB_TYPEMATIC_FILTER_EN
    if (!brk) begin
      if (tm_vld && tm_key == {code, ext}) sup = 1;
      else begin
        tm_key = {code, ext};
        tm_vld = 1;
      end
    end else if (tm_vld && tm_key == {code, ext}) begin
      tm_vld = 0;
    end
`endif
    if (!ext && code == 8'h12) lsh = !brk;
    if (!ext && code == 8'h59) rsh = !brk;
    if (code == 8'h14) begin
      if (ext) rct = !brk;
      else     lct = !brk;
    end
    if (!sup) begin
      if (exp_q.size() < Depth) exp_q.push_back(e);
      else ovf_m = 1;
    end
  endfunction

  // Accumulates a prefix sequence and emits once its final byte arrives.
  function automatic void model_byte(input byte unsigned b, input bit err);
    int n;
    if (err) begin
      seq.delete();
      pause_left = 0;
      return;
    end
    if (pause_left > 0) begin
      pause_left--;
      if (pause_left == 0) model_event(8'hE1, 0, 0);
      return;
    end
    seq.push_back(b);
    n = seq.size();
    if (n == 1 && b == 8'hE1) begin
      pause_left = 7;
      seq.delete();
      return;
    end
    if (n == 1 && (b == 8'hE0 || b == 8'hF0)) return;
    if (n == 2 && seq[0] == 8'hE0 && b == 8'hF0) return;
    if (n == 1 && (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'h00 || b == 8'hFF)) begin
      seq.delete();
      return;
    end
    model_event(b, seq[0] == 8'hE0, n >= 2 && seq[n-2] == 8'hF0);
    seq.delete();
  endfunction

  task automatic step(input bit v, input logic [7:0] d, input bit e, input bit rdy);
    @(negedge clk);
    check("valid", key_valid, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      check("code", key_code, exp_q[0].code);
      check("ext", key_ext, exp_q[0].ext);
      check("break", key_break, exp_q[0].brk);
      check("ascii", ascii, exp_q[0].asc);
    end
    check("shift", shift, lsh || rsh);
    check("ctrl", ctrl, lct || rct);
    check("overflow", overflow, ovf_m);
    if (exp_q.size() > 0 && rdy) begin
      void'(exp_q.pop_front());
      pops++;
    end
    frame_valid = v;
    frame_data  = d;
    frame_err   = e;
    key_ready   = rdy;
    if (v) model_byte(d, e);
    @(posedge clk);
    #1 frame_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, rdy);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n       = 1'b0;
    frame_valid = 1'b1;
    frame_data  = 8'h1C;
    key_ready   = 1'b0;
    @(posedge clk);
    #1 frame_valid = 1'b0;
    @(negedge clk);
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_ext", key_ext, 0);
    check("rst_break", key_break, 0);
    check("rst_ascii", ascii, 0);
    check("rst_shift", shift, 0);
    check("rst_ctrl", ctrl, 0);
    check("rst_overflow", overflow, 0);
    rst_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [7:0] rand_byte();
    case ($urandom_range(0, 11))
      0:       return 8'hE0;
      1, 2:    return 8'hF0;
      3:       return ($urandom_range(0, 7) == 0) ? 8'hE1 : 8'hAA;
      4:       return 8'h12;
      5:       return ($urandom_range(0, 1) != 0) ? 8'h59 : 8'h14;
      6, 7:    return letters[$urandom_range(0, 25)];
      8:       return digits[$urandom_range(0, 9)];
      9:       return ($urandom_range(0, 1) != 0) ? 8'h29 : 8'h66;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    int p0;
    model_reset();
    do_reset();

    // Make then break of 'a'.
    send(8'h1C); send(8'hF0); send(8'h1C); idle(3, 1);
    // Shift held around a letter.
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C); idle(3, 1);
    // Extended make/break and right Ctrl.
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'hE0); send(8'h14); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h14); idle(3, 1);

    // Five makes into a stalled FIFO: four held, overflow set, then drain.
    p0 = pops;
    step(1, 8'h1C, 0, 0); step(1, 8'h32, 0, 0); step(1, 8'h21, 0, 0);
    step(1, 8'h23, 0, 0); step(1, 8'h24, 0, 0);
    idle(2, 0);
    check("ovf_set", overflow, 1);
    idle(6, 1);
    check("drain_count", pops - p0, 4);

    // Reset mid-prefix, error after E0, then Pause sequence.
    do_reset();
    send(8'hE0); do_reset();
    send(8'h1C);
    send(8'hE0); step(1, 8'h75, 1, 1); send(8'h1C);
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77); idle(3, 1);

    // Auto-repeat of one key.
    p0 = pops;
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); idle(4, 1);
`ifdef KB_TYPEMATIC_FILTER_EN
    check("repeat_events", pops - p0, 2);
`else
    check("repeat_events", pops - p0, 4);
`endif

    // Randomized traffic with back-pressure, errors and occasional reset.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 3) != 0, rand_byte(), $urandom_range(0, 31) == 0,
           $urandom_range(0, 2) != 0);
    end
    idle(8, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
